// File: rtl/calc_pkg.sv
// Shared datapath constants for the SimpleCalculator operators.
package calc_pkg;
  localparam int OPERAND_W = 4;
  localparam int PRODUCT_W = 2 * OPERAND_W;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder; a half adder is this cell with cin tied low.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/csa_multiplier.sv
// Unsigned NxN carry-save array multiplier with a final ripple row and one
// registered output stage.
module csa_multiplier
  import calc_pkg::*;
#(
  parameter int N = OPERAND_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   m,
  input  logic [N-1:0]   q,
  output logic [2*N-1:0] p
);

  logic [2*N-1:0] p_d;
  logic [2*N-1:0] p_q;

  // Row i column j has weight 2^(i+j): it takes pp[i][j], the previous row's
  // sum one column to the left, and the previous row's carry in the same column.
  for (genvar i = 0; i < N; i++) begin : g_row
    logic [N-1:0] s;
    logic [N-1:0] c;
    if (i == 0) begin : g_init
      assign s = m & {N{q[0]}};
      assign c = '0;
    end else begin : g_add
      logic [N-1:0] s_in;
      assign s_in = {1'b0, g_row[i-1].s[N-1:1]};
      for (genvar j = 0; j < N; j++) begin : g_col
        full_adder u_fa (
          .a   (m[j] & q[i]),
          .b   (s_in[j]),
          .cin (g_row[i-1].c[j]),
          .s   (s[j]),
          .cout(c[j])
        );
      end
    end
    assign p_d[i] = s[0];
  end

  // Merge the leftover sum/carry vectors into the upper half of the product.
  for (genvar k = 0; k < N - 1; k++) begin : g_rip
    logic ci;
    logic co;
    if (k == 0) begin : g_c0
      assign ci = 1'b0;
    end else begin : g_cn
      assign ci = g_rip[k-1].co;
    end
    full_adder u_fa (
      .a   (g_row[N-1].s[k+1]),
      .b   (g_row[N-1].c[k]),
      .cin (ci),
      .s   (p_d[N+k]),
      .cout(co)
    );
  end

  // The product always fits in 2N bits, so these two never both fire.
  assign p_d[2*N-1] = g_rip[N-2].co | g_row[N-1].c[N-1];

  always_ff @(posedge clk) begin
    if (rst) p_q <= '0;
    else     p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: tb/tb_csa_multiplier.sv
// Self-checking bench: directed cases, exhaustive sweep and random traffic
// against a plain-arithmetic product model.
module tb_csa_multiplier;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   m;
  logic [N-1:0]   q;
  logic [2*N-1:0] p;

  int errs   = 0;
  int checks = 0;

  csa_multiplier #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .m  (m),
    .q  (q),
    .p  (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply operands for one edge, then compare p just after that edge.
  task automatic step(input string tag, input int mi, input int qi, input bit r);
    int exp;
    @(negedge clk);
    m   = mi[N-1:0];
    q   = qi[N-1:0];
    rst = r;
    exp = r ? 0 : mi * qi;
    @(posedge clk);
    #1;
    chk(tag, int'(p), exp);
  endtask

  initial begin
    int pairs [10][2];
    int hold;
    rst = 1'b1;
    m   = '0;
    q   = '0;

    step("rst_hold0", 15, 15, 1'b1);
    step("rst_hold1", 15, 15, 1'b1);
    step("rst_release", 15, 15, 1'b0);

    pairs = '{'{0,10}, '{5,5}, '{9,5}, '{12,13}, '{15,10},
              '{1,9}, '{8,8}, '{15,1}, '{15,15}, '{0,0}};
    foreach (pairs[i])
      step($sformatf("dir_%0dx%0d", pairs[i][0], pairs[i][1]),
           pairs[i][0], pairs[i][1], 1'b0);

    step("pre_mid_rst", 7, 7, 1'b0);
    step("mid_rst", 7, 7, 1'b1);
    step("post_mid_rst", 7, 7, 1'b0);

    // Operand glitches between edges must not reach p.
    @(negedge clk);
    hold = int'(p);
    m = 4'd3; q = 4'd11;
    #2;
    m = 4'd7; q = 4'd7;
    #1;
    chk("glitch_hold", int'(p), hold);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        step($sformatf("sweep_%0dx%0d", a, b), a, b, 1'b0);

    for (int k = 0; k < 300; k++)
      step("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           ($urandom_range(0, 15) == 0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/csa_multiplier.md
Name: csa_multiplier

Overview:
Unsigned 4x4 carry-save-array (CSA) multiplier producing an 8-bit product. Partial products are reduced through rows of full/half adders in carry-save form, then resolved by a final ripple-carry row. The result is registered once, so there is one-cycle latency. It sits in the SimpleCalculator datapath as the multiply operator.

Parameters:
- N, 4, operand width in bits; product width is 2*N. Only N=4 is required to be verified; the RTL stays generic where practical.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- m  input  N  multiplicand, unsigned
- q  input  N  multiplier, unsigned
- p  output  2N  product m*q, unsigned, registered

Behaviour:
- Reset: on a rising clk edge with rst=1, p <= 0. rst has priority over new operands.
- Normal operation: on each rising clk edge with rst=0, p <= m*q using the m and q values sampled at that edge. Latency is 1 cycle and the block accepts a new operand pair every cycle.
- No handshake is used. p holds its value until the next edge.
- Datapath is combinational from m/q to the D input of the p register:
  - Partial products pp[i][j] = m[j] & q[i].
  - Row 0 initialises the sum/carry vectors.
  - Rows 1..N-1 each add the next partial-product row to the shifted sum vector plus the carry vector, using full adders (half adders at the edges). Carries are not propagated within a row.
  - p[i] for i < N is taken as the LSB of each row.
  - A final N-1-bit ripple-carry adder merges the remaining sum and carry vectors into p[2N-1:N].
- Width rules: operands are unsigned and the product always fits in 2N bits, so there is no overflow or truncation. The maximum result is 15*15 = 225 = 8'hE1.
- Boundaries:
  - m=0 or q=0 gives p=0.
  - m=1 gives p={0,q}.
  - All-ones operands give 225.
- Reset mid-operation: the in-flight product is discarded and p=0 on that edge. The first valid product appears one edge after rst deasserts, using the operands present at that edge.
- m/q changes are sampled only at clock edges. Glitches between edges have no effect on p.

Decomposition:
- Shared package calc_pkg holds the constant N (default 4) and the product width 2*N.
- One natural sub-module, full_adder (a, b, cin -> s, cout), instantiated via generate loops for the CSA rows and the final ripple row.
- Half adders are expressed inline as full_adder instances with cin=0.

Test Plan:
- Hold rst=1 for 2 cycles with m=15, q=15 -> p=0 throughout. Deassert rst -> p=225 one cycle later.
- Apply m=0, q=10 -> p=0. Then m=5, q=5 -> p=25. Then m=9, q=5 -> p=45. Each result appears exactly one edge after the operands are applied.
- Apply m=12, q=13 -> p=156. Then m=15, q=10 -> p=150. Apply the pairs back-to-back on consecutive cycles and check one result per cycle.
- Corner cases: m=1, q=9 -> 9; m=8, q=8 -> 64; m=15, q=1 -> 15; m=15, q=15 -> 225.
- Assert rst for one cycle mid-stream while m=7, q=7 -> p=0 on that edge. Next edge with rst=0 -> p=49.
- Exhaustive sweep of all 256 (m,q) pairs, one per cycle -> p equals the reference m*q one cycle later, with zero mismatches.
